// File: rtl/adder_subtractor_4bit.sv
// Registered 4-bit two's-complement adder/subtractor built on one shared ripple-carry chain.
// sel inverts B and feeds the carry-in, so the same chain forms either A+B or A-B.
module adder_subtractor_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       sel,
  output logic [3:0] S,
  output logic       cout,
  output logic       ovf,
  output logic       zero
);

  logic [3:0] bx;
  logic [3:0] sum;
  logic [4:0] carry;

  logic [3:0] sum_reg;
  logic       cout_reg;
  logic       ovf_reg;
  logic       zero_reg;

  assign carry[0] = sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign bx[gi]        = B[gi] ^ sel;
      assign sum[gi]       = A[gi] ^ bx[gi] ^ carry[gi];
      assign carry[gi + 1] = (A[gi] & bx[gi]) | (carry[gi] & (A[gi] ^ bx[gi]));
    end
  endgenerate

  // Reset leaves a valid-looking all-zero result, hence zero comes up set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg  <= 4'b0000;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b1;
    end else begin
      sum_reg  <= sum;
      cout_reg <= carry[4];
      ovf_reg  <= carry[3] ^ carry[4];
      zero_reg <= ~|sum;
    end
  end

  assign S    = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

endmodule

// File: tb/tb_adder_subtractor_4bit.sv
// Scoreboard bench: the driver queues one expected result per cycle, the monitor pops and
// compares one entry after each rising edge.
module tb_adder_subtractor_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       sel;
  logic [3:0] S;
  logic       cout;
  logic       ovf;
  logic       zero;

  typedef struct {
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   fails     = 0;
  bit   done      = 0;

  adder_subtractor_4bit dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .sel  (sel),
    .S    (S),
    .cout (cout),
    .ovf  (ovf),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference written in integer arithmetic, independent of the carry chain.
  function automatic exp_t model(input int a, input int b, input bit sub, input int id);
    exp_t e;
    int   sa, sb, sr, ur;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    if (sub) begin
      ur     = a - b;
      sr     = sa - sb;
      e.cout = (a >= b);
    end else begin
      ur     = a + b;
      sr     = sa + sb;
      e.cout = (ur >= 16);
    end
    e.s    = 4'(ur & 15);
    e.ovf  = (sr > 7) || (sr < -8);
    e.zero = ((ur & 15) == 0);
    e.id   = id;
    return e;
  endfunction

  function automatic exp_t mk(input logic [3:0] s, input bit c, input bit o, input bit z, input int id);
    exp_t e;
    e.s = s; e.cout = c; e.ovf = o; e.zero = z; e.id = id;
    return e;
  endfunction

  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b, input logic sl, input exp_t e);
    @(negedge clk);
    rst = r; A = a; B = b; sel = sl;
    exp_q.push_back(e);
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic sl, input int id);
    drive(1'b0, a, b, sl, model(int'(a), int'(b), sl, id));
  endtask

  task automatic rst_cycle(input logic [3:0] a, input logic [3:0] b, input logic sl, input int id);
    drive(1'b1, a, b, sl, mk(4'b0000, 1'b0, 1'b0, 1'b1, id));
  endtask

  // Monitor: one result per edge while the scoreboard holds entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if ({S, cout, ovf, zero} !== {e.s, e.cout, e.ovf, e.zero}) begin
          fails++;
          $display("FAIL id=%0d got S=%b cout=%b ovf=%b zero=%b expected S=%b cout=%b ovf=%b zero=%b",
                   e.id, S, cout, ovf, zero, e.s, e.cout, e.ovf, e.zero);
        end else begin
          $display("[TB] id=%0d S=%b cout=%b ovf=%b zero=%b ok", e.id, S, cout, ovf, zero);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; A = 4'b1010; B = 4'b0110; sel = 1'b1;

    // Reset held for two edges with arbitrary operands.
    rst_cycle(4'b1010, 4'b0110, 1'b1, 1);
    rst_cycle(4'b1111, 4'b0001, 1'b0, 2);

    // Directed vectors with hand-computed results.
    drive(1'b0, 4'b0100, 4'b0100, 1'b0, mk(4'b1000, 1'b0, 1'b1, 1'b0, 10));
    drive(1'b0, 4'b0100, 4'b1101, 1'b0, mk(4'b0001, 1'b1, 1'b0, 1'b0, 11));
    drive(1'b0, 4'b1101, 4'b1100, 1'b1, mk(4'b0001, 1'b1, 1'b0, 1'b0, 12));
    drive(1'b0, 4'b0100, 4'b0100, 1'b1, mk(4'b0000, 1'b1, 1'b0, 1'b1, 13));
    drive(1'b0, 4'b0011, 4'b0101, 1'b1, mk(4'b1110, 1'b0, 1'b0, 1'b0, 14));
    drive(1'b0, 4'b0111, 4'b1000, 1'b1, mk(4'b1111, 1'b0, 1'b1, 1'b0, 15));
    drive(1'b0, 4'b1000, 4'b1000, 1'b0, mk(4'b0000, 1'b1, 1'b1, 1'b1, 16));
    drive(1'b0, 4'b1111, 4'b0001, 1'b0, mk(4'b0000, 1'b1, 1'b0, 1'b1, 17));
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, mk(4'b0000, 1'b1, 1'b0, 1'b1, 18));
    drive(1'b0, 4'b0000, 4'b0001, 1'b1, mk(4'b1111, 1'b0, 1'b0, 1'b0, 19));

    // Back-to-back with a one-cycle reset in the middle.
    op(4'b0110, 4'b0011, 1'b0, 30);
    op(4'b1001, 4'b0010, 1'b1, 31);
    rst_cycle(4'b0101, 4'b0101, 1'b0, 32);
    op(4'b0101, 4'b0101, 1'b0, 33);
    op(4'b1100, 4'b0111, 1'b1, 34);
    op(4'b0010, 4'b1110, 1'b0, 35);

    // Exhaustive sweep, mode toggling fastest.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int m = 0; m < 2; m++)
          op(4'(a), 4'(b), m[0], 1000 + a * 32 + b * 2 + m);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
    end
  end

endmodule

// File: doc/adder_subtractor_4bit.md
# adder_subtractor_4bit

Registered 4-bit two's-complement adder/subtractor for the datapath's arithmetic stage. It computes A+B or A−B from a single mode select using one shared ripple-carry adder: B is XORed with `sel` and `sel` is the carry-in. Sum and flags are captured on the clock edge, giving a fixed one-cycle latency with no handshake.

## Interface
- Parameters: none. Width is fixed at 4 bits.
- `clk`   input   1   Single clock. All state updates on the rising edge.
- `rst`   input   1   Reset. Synchronous, active-high.
- `A`     input   4   Operand A (unsigned or two's complement).
- `B`     input   4   Operand B.
- `sel`   input   1   Mode select. 0 = add (A+B); 1 = subtract (A−B).
- `S`     output  4   Registered result, low 4 bits.
- `cout`  output  1   Registered carry-out of bit 3. In subtract mode, 1 = no borrow (A ≥ B unsigned).
- `ovf`   output  1   Registered signed overflow: carry into bit 3 XOR carry out of bit 3.
- `zero`  output  1   Registered flag, 1 when S == 4'b0000.
- Port order: `clk`, `rst`, `A`, `B`, `sel`, `S`, `cout`, `ovf`, `zero`.

## Operation
- Effective operand: Bx = B ^ {4{sel}}. Carry-in c0 = `sel`.
- Four chained full adders, i = 0..3:
  - s_i = A_i ^ Bx_i ^ c_i
  - c_{i+1} = A_i·Bx_i | c_i·(A_i ^ Bx_i)
- Combinational result: {c4, s[3:0]} = A + Bx + sel, computed as a 5-bit result.
- Add mode: S = (A+B) mod 16, `cout` = 1 iff A+B ≥ 16.
- Subtract mode: S = (A−B) mod 16, `cout` = 1 iff A ≥ B unsigned.
- `ovf` = c3 ^ c4, in both modes.
- `zero` = ~|s[3:0].
- All operand values are legal. There are no illegal or reserved codes.

## Timing
- On each rising `clk` edge with `rst` = 0, the registers capture the results of the current A, B and `sel`:
  - S ← s[3:0]
  - `cout` ← c4
  - `ovf` ← c3^c4
  - `zero` ← ~|s
- Latency: exactly 1 cycle. Outputs reflect the inputs sampled at the previous rising edge.
- Throughput: one operation per cycle. Inputs may change every cycle, including `sel`.
- Between edges, outputs are stable. Input changes do not propagate to the outputs until the next edge.
- Reset, when `rst` = 1 at a rising edge:
  - S = 4'b0000, `cout` = 0, `ovf` = 0, `zero` = 1.
  - Reset takes priority over any operation sampled in that cycle.
- Reset mid-stream: the pending result is discarded. The first post-reset result appears one edge after the first edge with `rst` = 0.
- Before the first reset, output values are undefined. The bench must apply reset first.
- No X propagation from an unused mode: `sel` fully selects the operation.

## Test plan
- Reset: hold `rst` = 1 for 2 edges with arbitrary inputs -> S=0000, `cout`=0, `ovf`=0, `zero`=1.
- Add, no carry: A=0100, B=0100, `sel`=0 -> next edge S=1000, `cout`=0, `ovf`=1, `zero`=0.
- Add, wrap: A=0100, B=1101, `sel`=0 -> S=0001, `cout`=1, `ovf`=0, `zero`=0.
- Subtract, no borrow: A=1101, B=1100, `sel`=1 -> S=0001, `cout`=1, `ovf`=0, `zero`=0.
- Subtract, equal operands: A=0100, B=0100, `sel`=1 -> S=0000, `cout`=1, `ovf`=0, `zero`=1. Then A=0011, B=0101, `sel`=1 -> S=1110, `cout`=0 (borrow), `ovf`=0.
- Back-to-back and exhaustive:
  - Change inputs every cycle and assert `rst` for one cycle mid-sequence -> each output matches the expected result of inputs one edge earlier; the reset cycle yields reset values.
  - Sweep all 512 combinations of A, B and `sel` against a 5-bit reference model.
